aritmetik_mantik_birimi: RTL and testbench



---
 rtl/aritmetik_mantik_birimi.sv | 175 +++++++++++++++++
 tb/tb_aritmetik_mantik_birimi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aritmetik_mantik_birimi.sv
`default_nettype none
// ============================================================================
// Module  : aritmetik_mantik_birimi
// Brief   : 32-bit RV32I execute-stage ALU. Add/sub, bitwise logic, shifts,
//           set-less-than (signed/unsigned) and operand-2 pass-through.
//           A combinational result and zero flag serve forwarding/branch
//           logic; a registered copy with valid and zero flags feeds the
//           writeback pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
module aritmetik_mantik_birimi #(
    parameter int VERI_GENISLIGI = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [3:0]                kontrol_i,
    input  logic [VERI_GENISLIGI-1:0] deger1_i,
    input  logic [VERI_GENISLIGI-1:0] deger2_i,
    input  logic                      gecerli_i,
    output logic [VERI_GENISLIGI-1:0] sonuc_o,
    output logic                      sifir_o,
    output logic [VERI_GENISLIGI-1:0] sonuc_kayit_o,
    output logic                      sifir_kayit_o,
    output logic                      gecerli_o
);

    // Shift amount is always the low five bits of operand 2 (RV32I).
    localparam int KAYDIRMA_GENISLIGI = 5;
    localparam int KADEME_SAYISI      = KAYDIRMA_GENISLIGI;

    // Operation encodings shared with the decoder.
    localparam logic [3:0] AMB_TOPLAMA = 4'd0;
    localparam logic [3:0] AMB_CIKARMA = 4'd1;
    localparam logic [3:0] AMB_XOR     = 4'd2;
    localparam logic [3:0] AMB_OR      = 4'd3;
    localparam logic [3:0] AMB_AND     = 4'd4;
    localparam logic [3:0] AMB_SLL     = 4'd5;
    localparam logic [3:0] AMB_SRL     = 4'd6;
    localparam logic [3:0] AMB_SRA     = 4'd7;
    localparam logic [3:0] AMB_SLT     = 4'd8;
    localparam logic [3:0] AMB_SLTU    = 4'd9;
    localparam logic [3:0] AMB_GECIR   = 4'd10;

    // ------------------------------------------------------------------
    // Shared adder / subtractor. Subtraction and both compares use
    // d1 + ~d2 + 1, so a single carry chain serves all four operations.
    // ------------------------------------------------------------------
    logic                      w_cikarma_modu;
    logic [VERI_GENISLIGI-1:0] w_ikinci_islenen;
    logic [VERI_GENISLIGI:0]   w_toplam_genis;
    logic [VERI_GENISLIGI-1:0] w_toplam;
    logic                      w_elde;
    logic                      w_kucuk_isaretli;
    logic                      w_kucuk_isaretsiz;

    assign w_cikarma_modu   = (kontrol_i == AMB_CIKARMA) ||
                              (kontrol_i == AMB_SLT)     ||
                              (kontrol_i == AMB_SLTU);
    assign w_ikinci_islenen = w_cikarma_modu ? ~deger2_i : deger2_i;
    assign w_toplam_genis   = {1'b0, deger1_i}
                            + {1'b0, w_ikinci_islenen}
                            + {{VERI_GENISLIGI{1'b0}}, w_cikarma_modu};
    assign w_toplam         = w_toplam_genis[VERI_GENISLIGI-1:0];
    assign w_elde           = w_toplam_genis[VERI_GENISLIGI];

    // Unsigned less-than: no carry out of d1 + ~d2 + 1 means d1 < d2.
    assign w_kucuk_isaretsiz = ~w_elde;

    // Signed less-than: when signs differ the negative operand is smaller;
    // when they match the difference cannot overflow and its sign decides.
    assign w_kucuk_isaretli =
        (deger1_i[VERI_GENISLIGI-1] != deger2_i[VERI_GENISLIGI-1])
            ? deger1_i[VERI_GENISLIGI-1]
            : w_toplam[VERI_GENISLIGI-1];

    // ------------------------------------------------------------------
    // Barrel shifter. Only a right shifter is built; left shifts reverse
    // the operand on the way in and the result on the way out.
    // ------------------------------------------------------------------
    logic [KAYDIRMA_GENISLIGI-1:0]                  w_miktar;
    logic                                           w_sola;
    logic                                           w_dolgu;
    logic [VERI_GENISLIGI-1:0]                      w_ters_giris;
    logic [VERI_GENISLIGI-1:0]                      w_ters_cikis;
    logic [KADEME_SAYISI:0][VERI_GENISLIGI-1:0]     w_kademe;

    assign w_miktar = deger2_i[KAYDIRMA_GENISLIGI-1:0];
    assign w_sola   = (kontrol_i == AMB_SLL);
    // Sign fill only for arithmetic right shift; everything else zero-fills.
    assign w_dolgu  = (kontrol_i == AMB_SRA) && deger1_i[VERI_GENISLIGI-1];

    for (genvar i = 0; i < VERI_GENISLIGI; i++) begin : g_giris_ters
        assign w_ters_giris[i] = deger1_i[VERI_GENISLIGI-1-i];
    end

    assign w_kademe[0] = w_sola ? w_ters_giris : deger1_i;

    // Stage k shifts right by 2^k when bit k of the amount is set.
    for (genvar k = 0; k < KADEME_SAYISI; k++) begin : g_kademe
        localparam int ADIM = 1 << k;
        assign w_kademe[k+1] = w_miktar[k]
            ? {{ADIM{w_dolgu}}, w_kademe[k][VERI_GENISLIGI-1:ADIM]}
            : w_kademe[k];
    end

    for (genvar i = 0; i < VERI_GENISLIGI; i++) begin : g_cikis_ters
        assign w_ters_cikis[i] = w_kademe[KADEME_SAYISI][VERI_GENISLIGI-1-i];
    end

    // ------------------------------------------------------------------
    // Result select and zero flag (pure function of kontrol/operands).
    // ------------------------------------------------------------------
    logic [VERI_GENISLIGI-1:0] w_sonuc;
    logic                      w_sifir;

    // Pick the operation result; unused codes return zero.
    always_comb begin
        w_sonuc = '0;
        case (kontrol_i)
            AMB_TOPLAMA,
            AMB_CIKARMA: w_sonuc = w_toplam;
            AMB_XOR:     w_sonuc = deger1_i ^ deger2_i;
            AMB_OR:      w_sonuc = deger1_i | deger2_i;
            AMB_AND:     w_sonuc = deger1_i & deger2_i;
            AMB_SLL:     w_sonuc = w_ters_cikis;
            AMB_SRL,
            AMB_SRA:     w_sonuc = w_kademe[KADEME_SAYISI];
            AMB_SLT:     w_sonuc = {{(VERI_GENISLIGI-1){1'b0}}, w_kucuk_isaretli};
            AMB_SLTU:    w_sonuc = {{(VERI_GENISLIGI-1){1'b0}}, w_kucuk_isaretsiz};
            AMB_GECIR:   w_sonuc = deger2_i;
            default:     w_sonuc = '0;
        endcase
    end

    assign w_sifir = ~|w_sonuc;
    assign sonuc_o = w_sonuc;
    assign sifir_o = w_sifir;

    // ------------------------------------------------------------------
    // Writeback copy: capture on valid, hold otherwise.
    // ------------------------------------------------------------------
    logic [VERI_GENISLIGI-1:0] sonuc_kayit_q, sonuc_kayit_d;
    logic                      sifir_kayit_q, sifir_kayit_d;
    logic                      gecerli_q,     gecerli_d;

    // Next-state: new result only when the incoming operation is valid.
    always_comb begin
        sonuc_kayit_d = sonuc_kayit_q;
        sifir_kayit_d = sifir_kayit_q;
        gecerli_d     = gecerli_i;
        if (gecerli_i) begin
            sonuc_kayit_d = w_sonuc;
            sifir_kayit_d = w_sifir;
        end
    end

    // Pipeline register; reset clears it at once, dropping any in-flight result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sonuc_kayit_q <= '0;
            sifir_kayit_q <= 1'b0;
            gecerli_q     <= 1'b0;
        end else begin
            sonuc_kayit_q <= sonuc_kayit_d;
            sifir_kayit_q <= sifir_kayit_d;
            gecerli_q     <= gecerli_d;
        end
    end

    assign sonuc_kayit_o = sonuc_kayit_q;
    assign sifir_kayit_o = sifir_kayit_q;
    assign gecerli_o     = gecerli_q;

endmodule
`default_nettype wire

// File: tb/tb_aritmetik_mantik_birimi.sv
`default_nettype none
// ============================================================================
// Module  : tb_aritmetik_mantik_birimi
// Brief   : Scoreboard bench for aritmetik_mantik_birimi. The driver pushes
//           hand-computed expectations; monitors pop and compare.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aritmetik_mantik_birimi;

    localparam logic [3:0] AMB_TOPLAMA = 4'd0;
    localparam logic [3:0] AMB_CIKARMA = 4'd1;
    localparam logic [3:0] AMB_XOR     = 4'd2;
    localparam logic [3:0] AMB_OR      = 4'd3;
    localparam logic [3:0] AMB_AND     = 4'd4;
    localparam logic [3:0] AMB_SLL     = 4'd5;
    localparam logic [3:0] AMB_SRL     = 4'd6;
    localparam logic [3:0] AMB_SRA     = 4'd7;
    localparam logic [3:0] AMB_SLT     = 4'd8;
    localparam logic [3:0] AMB_SLTU    = 4'd9;
    localparam logic [3:0] AMB_GECIR   = 4'd10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  kontrol_i = '0;
    logic [31:0] deger1_i = '0;
    logic [31:0] deger2_i = '0;
    logic        gecerli_i = 1'b0;
    logic [31:0] sonuc_o;
    logic        sifir_o;
    logic [31:0] sonuc_kayit_o;
    logic        sifir_kayit_o;
    logic        gecerli_o;

    aritmetik_mantik_birimi #(.VERI_GENISLIGI(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .kontrol_i    (kontrol_i),
        .deger1_i     (deger1_i),
        .deger2_i     (deger2_i),
        .gecerli_i    (gecerli_i),
        .sonuc_o      (sonuc_o),
        .sifir_o      (sifir_o),
        .sonuc_kayit_o(sonuc_kayit_o),
        .sifir_kayit_o(sifir_kayit_o),
        .gecerli_o    (gecerli_o)
    );

    always #10 clk_i = ~clk_i;

    typedef struct {
        string       ad;
        logic [31:0] sonuc;
        logic        sifir;
    } beklenen_t;

    beklenen_t komb_q[$];
    beklenen_t kayit_q[$];

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    logic [31:0] tut_sonuc = '0;
    logic        tut_sifir = 1'b0;
    logic        ara_sifirlama = 1'b0;

    task automatic karsilastir(input string ad, input logic [31:0] gercek,
                               input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", ad, gercek, beklenen);
        end
    endtask

    // Drive one operation 2 ns after the rising edge; expectation goes to
    // both scoreboards when the operation is marked valid.
    task automatic gonder(input logic [3:0] k, input logic [31:0] a,
                          input logic [31:0] b, input logic g,
                          input logic [31:0] beklenen, input string ad);
        beklenen_t e;
        @(posedge clk_i);
        #2;
        kontrol_i = k;
        deger1_i  = a;
        deger2_i  = b;
        gecerli_i = g;
        if (g) begin
            e.ad    = ad;
            e.sonuc = beklenen;
            e.sifir = (beklenen == 32'h0);
            komb_q.push_back(e);
            kayit_q.push_back(e);
        end
    endtask

    // Monitor: samples 12 ns after each rising edge (10 ns after inputs change).
    initial begin
        beklenen_t e;
        forever begin
            @(posedge clk_i);
            #12;
            if (gecerli_i) begin
                if (komb_q.size() == 0) begin
                    karsilastir("komb_kuyruk_bos", 32'h1, 32'h0);
                end else begin
                    e = komb_q.pop_front();
                    karsilastir({"komb_", e.ad}, sonuc_o, e.sonuc);
                    karsilastir({"komb_sifir_", e.ad}, {31'b0, sifir_o}, {31'b0, e.sifir});
                end
            end
            if (!rst_ni) begin
                karsilastir("reset_sonuc_kayit", sonuc_kayit_o, 32'h0);
                karsilastir("reset_sifir_gecerli", {30'b0, sifir_kayit_o, gecerli_o}, 32'h0);
                tut_sonuc = '0;
                tut_sifir = 1'b0;
            end else if (gecerli_o === 1'b1) begin
                if (kayit_q.size() == 0) begin
                    karsilastir("kayit_beklenmeyen", sonuc_kayit_o, 32'hxxxx_xxxx);
                end else begin
                    e = kayit_q.pop_front();
                    karsilastir({"kayit_", e.ad}, sonuc_kayit_o, e.sonuc);
                    karsilastir({"kayit_sifir_", e.ad}, {31'b0, sifir_kayit_o}, {31'b0, e.sifir});
                    tut_sonuc = e.sonuc;
                    tut_sifir = e.sifir;
                end
            end else begin
                karsilastir("tut_gecerli", {31'b0, gecerli_o}, 32'h0);
                karsilastir("tut_sonuc", sonuc_kayit_o, tut_sonuc);
                karsilastir("tut_sifir", {31'b0, sifir_kayit_o}, {31'b0, tut_sifir});
            end
        end
    end

    // Asynchronous reset monitor: outputs must clear before any clock edge.
    always @(negedge rst_ni) begin
        if (ara_sifirlama) begin
            #1;
            karsilastir("async_reset_sonuc", sonuc_kayit_o, 32'h0);
            karsilastir("async_reset_gecerli", {31'b0, gecerli_o}, 32'h0);
            karsilastir("async_reset_sifir", {31'b0, sifir_kayit_o}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        // First capture happens on the first edge after release.
        gonder(AMB_TOPLAMA, 32'd80, 32'd70, 1'b1, 32'd150, "toplama_80_70");
        #3 rst_ni = 1'b1;
        gonder(AMB_CIKARMA, 32'd80,        32'd70,        1'b1, 32'd10,        "cikarma_80_70");
        gonder(AMB_CIKARMA, 32'd0,         32'd1,         1'b1, 32'hFFFF_FFFF, "cikarma_0_1");
        gonder(AMB_XOR,     32'hF0F0_F0F0, 32'hFF0F_0F0F, 1'b1, 32'h0FFF_FFFF, "xor");
        gonder(AMB_OR,      32'hF0F0_F0F0, 32'hFF0F_0F0F, 1'b1, 32'hFFFF_FFFF, "or");
        gonder(AMB_AND,     32'hF0F0_F0F0, 32'hFF0F_0F0F, 1'b1, 32'hF000_0000, "and");
        gonder(AMB_SLL,     32'hF0F0_F0F0, 32'd4,         1'b1, 32'h0F0F_0F00, "sll_4");
        gonder(AMB_SRL,     32'hF0F0_F0F0, 32'd4,         1'b1, 32'h0F0F_0F0F, "srl_4");
        gonder(AMB_SRA,     32'hF0F0_F0F0, 32'd4,         1'b1, 32'hFF0F_0F0F, "sra_4");
        gonder(AMB_SLL,     32'hF0F0_F0F0, 32'h24,        1'b1, 32'h0F0F_0F00, "sll_24");
        gonder(AMB_SRL,     32'hF0F0_F0F0, 32'h24,        1'b1, 32'h0F0F_0F0F, "srl_24");
        gonder(AMB_SRA,     32'hF0F0_F0F0, 32'hFFFF_FFE4, 1'b1, 32'hFF0F_0F0F, "sra_ffffffe4");
        gonder(AMB_SLT,     32'hF0F0_F0F0, 32'd4,         1'b1, 32'd1,         "slt");
        gonder(AMB_SLTU,    32'hF0F0_F0F0, 32'd4,         1'b1, 32'd0,         "sltu");
        gonder(AMB_GECIR,   32'hF0F0_F0F0, 32'd4,         1'b1, 32'h0000_0004, "gecir");
        gonder(4'd15,       32'hF0F0_F0F0, 32'd4,         1'b1, 32'd0,         "kod15");
        gonder(4'd11,       32'h1234_5678, 32'h1,         1'b1, 32'd0,         "kod11");
        gonder(AMB_SLL,     32'h1234_5678, 32'd0,         1'b1, 32'h1234_5678, "sll_0");
        gonder(AMB_SRA,     32'h8765_4321, 32'd0,         1'b1, 32'h8765_4321, "sra_0");
        gonder(AMB_SRA,     32'h8000_0000, 32'd31,        1'b1, 32'hFFFF_FFFF, "sra_31");
        gonder(AMB_SRL,     32'h8000_0000, 32'd31,        1'b1, 32'h0000_0001, "srl_31");
        gonder(AMB_SLL,     32'h0000_0001, 32'd31,        1'b1, 32'h8000_0000, "sll_31");
        gonder(AMB_TOPLAMA, 32'h7FFF_FFFF, 32'd1,         1'b1, 32'h8000_0000, "tasma");
        gonder(AMB_TOPLAMA, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'h0000_0000, "toplama_sarma");
        gonder(AMB_SLT,     32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0,         "slt_esit");
        gonder(AMB_SLT,     32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'd1,         "slt_min_max");
        gonder(AMB_SLTU,    32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'd0,         "sltu_min_max");
        gonder(AMB_SLT,     32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'd0,         "slt_max_min");
        gonder(AMB_SLTU,    32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'd1,         "sltu_max_min");
        gonder(AMB_SLT,     32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 32'd1,         "slt_neg");
        // Registered path: capture then hold.
        gonder(AMB_TOPLAMA, 32'd5,         32'd6,         1'b1, 32'd11,        "kayit_5_6");
        gonder(AMB_CIKARMA, 32'd9,         32'd9,         1'b0, 32'd0,         "bos");
        gonder(AMB_XOR,     32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'd0,         "bos");
        // Reset while a valid result is showing and another is in flight.
        gonder(AMB_TOPLAMA, 32'd7,         32'd8,         1'b1, 32'd15,        "onceki_7_8");
        gonder(AMB_TOPLAMA, 32'd1,         32'd2,         1'b1, 32'd3,         "ucusta_1_2");
        #3;
        ara_sifirlama = 1'b1;
        rst_ni = 1'b0;
        kayit_q.delete();
        gonder(AMB_TOPLAMA, 32'd0, 32'd0, 1'b0, 32'd0, "bos");
        gonder(AMB_TOPLAMA, 32'd0, 32'd0, 1'b0, 32'd0, "bos");
        ara_sifirlama = 1'b0;
        gonder(AMB_TOPLAMA, 32'd9,         32'd9,         1'b1, 32'd18,        "serbest_9_9");
        #3 rst_ni = 1'b1;
        gonder(AMB_CIKARMA, 32'd3,         32'd3,         1'b1, 32'd0,         "cikarma_sifir");
        gonder(AMB_OR,      32'd0,         32'd0,         1'b0, 32'd0,         "bos");
        repeat (3) gonder(AMB_TOPLAMA, 32'd0, 32'd0, 1'b0, 32'd0, "bos");
        @(posedge clk_i);
        #15;
        karsilastir("kayit_kuyrugu_bos", kayit_q.size(), 32'd0);
        karsilastir("komb_kuyrugu_bos", komb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
        $finish;
    end

endmodule
`default_nettype wire
